elevator_call_scheduler: RTL and testbench
==========================================

Name: elevator_call_scheduler

Overview:
- Multi-floor elevator controller: latches floor call requests, picks travel direction with a SCAN (keep-direction) policy, drives motor up/down, counts floor-arrival pulses, and times door-open dwell with hold extension.
- Sits between the call-button panel (car and hall buttons ORed per floor) and the motor/door actuators.
- Replaces the single-request two-floor behaviour with queued, multi-floor service.

Parameters:
NUM_FLOORS, 4, number of floors served (2..16); floor 0 is the bottom floor.
DOOR_CYCLES, 8, clock cycles the door stays open after arrival or after the last hold/re-call.
FLOOR_W, $clog2(NUM_FLOORS), width of floor index (derived, not overridable).

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  synchronous active-low reset
call_req  input  NUM_FLOORS  per-floor call; any cycle high latches a request for that floor
floor_arrive  input  1  one-cycle pulse from shaft sensor: car reached the next floor in the travel direction
hold  input  1  door-hold button; level-sensitive
motor_up  output  1  drive car upward
motor_down  output  1  drive car downward
door_open  output  1  door open command
cur_floor  output  FLOOR_W  current floor index
dir_up  output  1  last/current travel direction (1 = up)
pending  output  NUM_FLOORS  latched outstanding requests

Behaviour:
- One clock; reset is synchronous and active-low: reset_n low at a rising edge of clk resets the block. Reset overrides everything, including mid-travel and door-open.
- Reset values: state IDLE, cur_floor 0, dir_up 1, pending 0, door counter 0, and all of motor_up/motor_down/door_open 0.
- All outputs are registered; actuator outputs reflect the state entered at the same edge.
- FSM states: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN (encoding in package).
- pending update each cycle: pending <= (pending | call_req) & ~clear_mask. clear_mask is the one-hot of the floor being served this cycle. Clear wins over a simultaneous set for the same floor.
- above = |pending bits > cur_floor; below = |pending bits < cur_floor.
- IDLE:
  - call_req or pending at cur_floor -> DOOR_OPEN, clear that bit, load counter.
  - else if dir_up and above -> MOVE_UP.
  - else if below -> MOVE_DOWN, dir_up<=0.
  - else if above -> MOVE_UP, dir_up<=1.
  - else stay.
- MOVE_UP: motor_up=1. On floor_arrive, cur_floor<=cur_floor+1, saturating at NUM_FLOORS-1. Then:
  - if the new floor is pending -> DOOR_OPEN, clear bit, load counter.
  - else if nothing above the new floor -> IDLE.
  - else stay.
- MOVE_DOWN: mirror of MOVE_UP; cur_floor saturates at 0.
- Defensive stop: in MOVE_UP at the top floor or MOVE_DOWN at floor 0 -> IDLE without moving. floor_arrive is ignored there.
- floor_arrive is ignored in IDLE and DOOR_OPEN.
- DOOR_OPEN: door_open=1, motors 0.
  - Counter decrements each cycle.
  - hold high or call_req for cur_floor reloads the counter to DOOR_CYCLES-1; the pending bit for cur_floor stays clear.
  - Counter reaching 0 with hold low -> IDLE.
  - Door dwell with no hold is exactly DOOR_CYCLES cycles of door_open=1.
- motor_up and motor_down are never both 1. Motor and door_open are never both 1.
- Minimum latency: call to a different floor while in IDLE -> motor asserted 2 cycles after the call_req edge (latch, then decide).

Decomposition:
- Package elevator_pkg holds:
  - state enum/localparams ST_IDLE, ST_MOVE_UP, ST_MOVE_DOWN, ST_DOOR_OPEN;
  - DOOR_CNT_W function;
  - default NUM_FLOORS.
- One natural sub-module: elevator_req_scan. It is combinational and computes above, below and hit_cur from pending and cur_floor. It is reused by future multi-car arbitration.

Test Plan:
- Reset mid-travel: car moving up at floor 2, reset_n low 1 cycle -> next cycle cur_floor 0, all outputs 0, pending 0.
- Single call: IDLE at 0, call_req=4'b1000 one cycle -> motor_up after 2 cycles. After three floor_arrive pulses, cur_floor=3, door_open=1 for exactly 8 cycles, then IDLE, pending 0.
- SCAN order: at floor 1 moving up with pending floors 0 and 3 -> serve 3 first, then reverse (dir_up=0), serve 0; floor 2 is passed without stopping.
- Hold: door open at floor 2, hold high for 20 cycles -> door_open stays 1 throughout; it drops 8 cycles after hold falls.
- Simultaneous set/clear: call_req for floor 2 in the same cycle floor_arrive brings the car to floor 2 -> bit 2 cleared, door opens once, no second stop.
- Call at current floor while IDLE -> DOOR_OPEN next cycle, motors never assert, pending stays 0.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared state encoding and sizing helpers for the elevator call scheduler.
package elevator_pkg;

  localparam int DEFAULT_NUM_FLOORS = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MOVE_UP   = 2'd1,
    ST_MOVE_DOWN = 2'd2,
    ST_DOOR_OPEN = 2'd3
  } state_t;

  // Counter only needs to hold DOOR_CYCLES-1; never narrower than one bit.
  function automatic int DOOR_CNT_W(input int door_cycles);
    return (door_cycles <= 2) ? 1 : $clog2(door_cycles);
  endfunction

endpackage

// File: rtl/elevator_req_scan.sv
// Combinational request scan: is anything pending above, below or at a given floor.
module elevator_req_scan
  import elevator_pkg::*;
#(
  parameter  int NUM_FLOORS = DEFAULT_NUM_FLOORS,
  localparam int FLOOR_W    = $clog2(NUM_FLOORS)
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]    floor,
  output logic                  above,
  output logic                  below,
  output logic                  hit
);

  logic [NUM_FLOORS-1:0] above_bits;
  logic [NUM_FLOORS-1:0] below_bits;
  logic [NUM_FLOORS-1:0] hit_bits;

  for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_floor
    assign above_bits[gi] = pending[gi] && (FLOOR_W'(gi) > floor);
    assign below_bits[gi] = pending[gi] && (FLOOR_W'(gi) < floor);
    assign hit_bits[gi]   = pending[gi] && (FLOOR_W'(gi) == floor);
  end

  assign above = |above_bits;
  assign below = |below_bits;
  assign hit   = |hit_bits;

endmodule

// File: rtl/elevator_call_scheduler.sv
// Single-car SCAN scheduler: latches calls, drives the motor between floors and
// times the door dwell with hold/re-call extension.
module elevator_call_scheduler
  import elevator_pkg::*;
#(
  parameter  int NUM_FLOORS  = DEFAULT_NUM_FLOORS,
  parameter  int DOOR_CYCLES = 8,
  localparam int FLOOR_W     = $clog2(NUM_FLOORS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_FLOORS-1:0] call_req,
  input  logic                  floor_arrive,
  input  logic                  hold,
  output logic                  motor_up,
  output logic                  motor_down,
  output logic                  door_open,
  output logic [FLOOR_W-1:0]    cur_floor,
  output logic                  dir_up,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int                 CNT_W     = DOOR_CNT_W(DOOR_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_LOAD  = CNT_W'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);

  state_t                state;
  logic [CNT_W-1:0]      door_cnt;
  logic [NUM_FLOORS-1:0] pend_now;
  logic [NUM_FLOORS-1:0] clear_mask;
  logic [FLOOR_W-1:0]    next_floor;
  logic                  above_cur, below_cur, hit_cur;
  logic                  above_next, below_next, hit_next;
  logic                  hit_here, arrive_up, arrive_down;

  // A call arriving this cycle counts immediately for stop decisions, so a
  // same-cycle call at the arrival floor is served rather than left behind.
  assign pend_now    = pending | call_req;
  assign hit_here    = hit_cur | call_req[cur_floor];
  assign arrive_up   = (state == ST_MOVE_UP) && floor_arrive && (cur_floor != TOP_FLOOR);
  assign arrive_down = (state == ST_MOVE_DOWN) && floor_arrive && (cur_floor != '0);

  always_comb begin
    next_floor = cur_floor;
    if (arrive_up)
      next_floor = cur_floor + 1'b1;
    else if (arrive_down)
      next_floor = cur_floor - 1'b1;
  end

  always_comb begin
    clear_mask = '0;
    if ((state == ST_IDLE && hit_here) || state == ST_DOOR_OPEN)
      clear_mask[cur_floor] = 1'b1;
    else if ((arrive_up || arrive_down) && hit_next)
      clear_mask[next_floor] = 1'b1;
  end

  elevator_req_scan #(.NUM_FLOORS(NUM_FLOORS)) u_scan_cur (
    .pending (pending),
    .floor   (cur_floor),
    .above   (above_cur),
    .below   (below_cur),
    .hit     (hit_cur)
  );

  elevator_req_scan #(.NUM_FLOORS(NUM_FLOORS)) u_scan_next (
    .pending (pend_now),
    .floor   (next_floor),
    .above   (above_next),
    .below   (below_next),
    .hit     (hit_next)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cur_floor  <= '0;
      dir_up     <= 1'b1;
      pending    <= '0;
      door_cnt   <= '0;
      motor_up   <= 1'b0;
      motor_down <= 1'b0;
      door_open  <= 1'b0;
    end else begin
      pending <= pend_now & ~clear_mask;
      case (state)
        ST_IDLE: begin
          if (hit_here) begin
            state     <= ST_DOOR_OPEN;
            door_open <= 1'b1;
            door_cnt  <= CNT_LOAD;
          end else if (dir_up && above_cur) begin
            state    <= ST_MOVE_UP;
            motor_up <= 1'b1;
          end else if (below_cur) begin
            state      <= ST_MOVE_DOWN;
            motor_down <= 1'b1;
            dir_up     <= 1'b0;
          end else if (above_cur) begin
            state    <= ST_MOVE_UP;
            motor_up <= 1'b1;
            dir_up   <= 1'b1;
          end
        end
        ST_MOVE_UP: begin
          if (cur_floor == TOP_FLOOR) begin
            state    <= ST_IDLE;
            motor_up <= 1'b0;
          end else if (floor_arrive) begin
            cur_floor <= next_floor;
            if (hit_next) begin
              state     <= ST_DOOR_OPEN;
              motor_up  <= 1'b0;
              door_open <= 1'b1;
              door_cnt  <= CNT_LOAD;
            end else if (!above_next) begin
              state    <= ST_IDLE;
              motor_up <= 1'b0;
            end
          end
        end
        ST_MOVE_DOWN: begin
          if (cur_floor == '0) begin
            state      <= ST_IDLE;
            motor_down <= 1'b0;
          end else if (floor_arrive) begin
            cur_floor <= next_floor;
            if (hit_next) begin
              state      <= ST_DOOR_OPEN;
              motor_down <= 1'b0;
              door_open  <= 1'b1;
              door_cnt   <= CNT_LOAD;
            end else if (!below_next) begin
              state      <= ST_IDLE;
              motor_down <= 1'b0;
            end
          end
        end
        ST_DOOR_OPEN: begin
          if (hold || call_req[cur_floor]) begin
            door_cnt <= CNT_LOAD;
          end else if (door_cnt == '0) begin
            state     <= ST_IDLE;
            door_open <= 1'b0;
          end else begin
            door_cnt <= door_cnt - 1'b1;
          end
        end
        default: begin
          state      <= ST_IDLE;
          motor_up   <= 1'b0;
          motor_down <= 1'b0;
          door_open  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Scoreboard bench: each expected output change (with its cycle gap) is queued
// by the stimulus and matched by a monitor that watches every output change.
module tb_elevator_call_scheduler;

  localparam int NF = 4;
  localparam int DC = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [NF-1:0] call_req;
  logic          floor_arrive;
  logic          hold;
  logic          motor_up;
  logic          motor_down;
  logic          door_open;
  logic [1:0]    cur_floor;
  logic          dir_up;
  logic [NF-1:0] pending;

  typedef struct {
    string      name;
    int         gap;
    logic [9:0] vec;
  } ev_t;

  ev_t        exp_q[$];
  int         checks   = 0;
  int         passed   = 0;
  int         cyc      = 0;
  int         last_cyc = 0;
  logic [9:0] last_vec = 'x;

  elevator_call_scheduler #(
    .NUM_FLOORS  (NF),
    .DOOR_CYCLES (DC)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .call_req     (call_req),
    .floor_arrive (floor_arrive),
    .hold         (hold),
    .motor_up     (motor_up),
    .motor_down   (motor_down),
    .door_open    (door_open),
    .cur_floor    (cur_floor),
    .dir_up       (dir_up),
    .pending      (pending)
  );

  always #5 clk = ~clk;

  // vec = {motor_up, motor_down, door_open, cur_floor, dir_up, pending}; gap 0 = not timed
  task automatic expect_ev(input string name, input int gap, input logic mu, input logic md,
                           input logic door, input logic [1:0] fl, input logic dir,
                           input logic [3:0] pend);
    ev_t e;
    e.name = name;
    e.gap  = gap;
    e.vec  = {mu, md, door, fl, dir, pend};
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic arrive();
    floor_arrive = 1'b1;
    step(1);
    floor_arrive = 1'b0;
  endtask

  task automatic call(input logic [NF-1:0] f);
    call_req = f;
    step(1);
    call_req = '0;
  endtask

  initial begin : monitor
    ev_t        e;
    logic [9:0] obs;
    forever begin
      @(negedge clk);
      cyc++;
      obs = {motor_up, motor_down, door_open, cur_floor, dir_up, pending};
      if (obs !== last_vec) begin
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_change cyc=%0d got=%b required=no change", cyc, obs);
        end else begin
          e = exp_q.pop_front();
          if (obs === e.vec) begin
            passed++;
            $display("ok   %s cyc=%0d out=%b", e.name, cyc, obs);
          end else begin
            $display("FAIL %s cyc=%0d got=%b required=%b", e.name, cyc, obs, e.vec);
          end
          if (e.gap != 0) begin
            checks++;
            if (cyc - last_cyc == e.gap)
              passed++;
            else
              $display("FAIL %s_gap cyc=%0d got=%0d required=%0d", e.name, cyc, cyc - last_cyc, e.gap);
          end
        end
        last_vec = obs;
        last_cyc = cyc;
      end
    end
  end

  initial begin : stimulus
    reset_n      = 1'b0;
    call_req     = '0;
    floor_arrive = 1'b0;
    hold         = 1'b0;

    expect_ev("reset", 0, 0, 0, 0, 2'd0, 1, 4'b0000);
    step(2);
    reset_n = 1'b1;

    // Call at the current floor while idle: door opens at once, motors stay off
    expect_ev("here_door_on",  0, 0, 0, 1, 2'd0, 1, 4'b0000);
    expect_ev("here_door_off", 8, 0, 0, 0, 2'd0, 1, 4'b0000);
    call(4'b0001);
    step(10);

    // Single call to the top floor
    expect_ev("s3_latch",    0, 0, 0, 0, 2'd0, 1, 4'b1000);
    expect_ev("s3_motor",    1, 1, 0, 0, 2'd0, 1, 4'b1000);
    expect_ev("s3_f1",       1, 1, 0, 0, 2'd1, 1, 4'b1000);
    expect_ev("s3_f2",       3, 1, 0, 0, 2'd2, 1, 4'b1000);
    expect_ev("s3_door_on",  3, 0, 0, 1, 2'd3, 1, 4'b0000);
    expect_ev("s3_door_off", 8, 0, 0, 0, 2'd3, 1, 4'b0000);
    call(4'b1000);
    step(1);
    arrive();
    step(2);
    arrive();
    step(2);
    arrive();
    step(10);

    // Call at floor 2 in the same cycle the car arrives there going down
    expect_ev("s4_latch",    0, 0, 0, 0, 2'd3, 1, 4'b0001);
    expect_ev("s4_down",     1, 0, 1, 0, 2'd3, 0, 4'b0001);
    expect_ev("s4_f2_door",  1, 0, 0, 1, 2'd2, 0, 4'b0001);
    expect_ev("s4_f2_close", 8, 0, 0, 0, 2'd2, 0, 4'b0001);
    expect_ev("s4_down2",    1, 0, 1, 0, 2'd2, 0, 4'b0001);
    expect_ev("s4_f1",       1, 0, 1, 0, 2'd1, 0, 4'b0001);
    expect_ev("s4_f0_door",  2, 0, 0, 1, 2'd0, 0, 4'b0000);
    expect_ev("s4_f0_close", 8, 0, 0, 0, 2'd0, 0, 4'b0000);
    call(4'b0001);
    step(1);
    call_req     = 4'b0100;
    floor_arrive = 1'b1;
    step(1);
    call_req     = '0;
    floor_arrive = 1'b0;
    step(9);
    arrive();
    step(1);
    arrive();
    step(10);

    // SCAN: moving up past floor 1 with floors 0 and 3 pending
    expect_ev("s5_latch",     0, 0, 0, 0, 2'd0, 0, 4'b1000);
    expect_ev("s5_up",        1, 1, 0, 0, 2'd0, 1, 4'b1000);
    expect_ev("s5_f1",        1, 1, 0, 0, 2'd1, 1, 4'b1000);
    expect_ev("s5_late_call", 1, 1, 0, 0, 2'd1, 1, 4'b1001);
    expect_ev("s5_f2_pass",   1, 1, 0, 0, 2'd2, 1, 4'b1001);
    expect_ev("s5_f3_door",   1, 0, 0, 1, 2'd3, 1, 4'b0001);
    expect_ev("s5_f3_close",  8, 0, 0, 0, 2'd3, 1, 4'b0001);
    expect_ev("s5_reverse",   1, 0, 1, 0, 2'd3, 0, 4'b0001);
    expect_ev("s5_f2",        1, 0, 1, 0, 2'd2, 0, 4'b0001);
    expect_ev("s5_f1_down",   1, 0, 1, 0, 2'd1, 0, 4'b0001);
    expect_ev("s5_f0_door",   1, 0, 0, 1, 2'd0, 0, 4'b0000);
    expect_ev("s5_f0_close",  8, 0, 0, 0, 2'd0, 0, 4'b0000);
    call(4'b1000);
    step(1);
    arrive();
    call(4'b0001);
    arrive();
    arrive();
    step(9);
    arrive();
    arrive();
    arrive();
    step(10);

    // Door hold for 20 cycles at floor 2
    expect_ev("s6_latch",        0, 0, 0, 0, 2'd0, 0, 4'b0100);
    expect_ev("s6_up",           1, 1, 0, 0, 2'd0, 1, 4'b0100);
    expect_ev("s6_f1",           1, 1, 0, 0, 2'd1, 1, 4'b0100);
    expect_ev("s6_f2_door",      1, 0, 0, 1, 2'd2, 1, 4'b0000);
    expect_ev("s6_hold_release", 28, 0, 0, 0, 2'd2, 1, 4'b0000);
    call(4'b0100);
    step(1);
    arrive();
    arrive();
    hold = 1'b1;
    step(20);
    hold = 1'b0;
    step(12);

    // Reset while moving up from floor 2, with a call present during reset
    expect_ev("s7_latch", 0, 0, 0, 0, 2'd2, 1, 4'b1000);
    expect_ev("s7_up",    1, 1, 0, 0, 2'd2, 1, 4'b1000);
    expect_ev("s7_reset", 1, 0, 0, 0, 2'd0, 1, 4'b0000);
    call(4'b1000);
    step(1);
    reset_n  = 1'b0;
    call_req = 4'b0010;
    step(1);
    reset_n  = 1'b1;
    call_req = '0;
    step(5);

    for (int i = 0; i < 100 && exp_q.size() != 0; i++)
      step(1);
    checks++;
    if (exp_q.size() == 0)
      passed++;
    else
      $display("FAIL queue_drain left=%0d required=0", exp_q.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
